// File: rtl/axi4_stream_rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module : axi4_stream_arb_pkg
//  Brief  : Shared types and the round-robin search helper for the stream arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
package axi4_stream_arb_pkg;

    localparam int c_MAX_N  = 16;
    localparam int c_MAX_PW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // First set bit of req searching ptr+1, ptr+2, ... modulo n, returned one-hot.
    function automatic logic [c_MAX_N-1:0] rr_first(
        input logic [c_MAX_N-1:0]  req,
        input logic [c_MAX_PW-1:0] ptr,
        input int                  n
    );
        logic [c_MAX_N-1:0] w_oh;
        logic               w_found;
        int                 c;
        w_oh    = '0;
        w_found = 1'b0;
        for (int k = 0; k < c_MAX_N; k++) begin
            c = int'(ptr) + 1 + k;
            if (c >= n) c = c - n;
            if ((k < n) && !w_found && req[c[c_MAX_PW-1:0]]) begin
                w_oh[c[c_MAX_PW-1:0]] = 1'b1;
                w_found               = 1'b1;
            end
        end
        return w_oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_stream_rr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module : axi4_stream_rr_arb_if
//  Brief  : AXI4-Stream bundle carrying NL parallel lanes (NL=1 for a single stream).
//  Rev    : 1.0  initial release
// ============================================================================
interface axi4_stream_rr_arb_if #(
    parameter int NL = 1,
    parameter int DW = 16
) ();
    localparam int KW = DW / 8;

    logic [NL-1:0]    TVALID;
    logic [NL-1:0]    TREADY;
    logic [NL*DW-1:0] TDATA;
    logic [NL*KW-1:0] TKEEP;
    logic [NL-1:0]    TLAST;

    modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface
`default_nettype wire

// File: rtl/axi4_stream_rr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module : rr_pick
//  Brief  : Combinational round-robin pick: one-hot winner and its index.
//  Rev    : 1.0  initial release
// ============================================================================
module rr_pick
    import axi4_stream_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [PW-1:0] i_ptr,
    output logic      [N-1:0]  o_onehot,
    output logic      [PW-1:0] o_idx
);

    logic [c_MAX_N-1:0]  w_req_pad;
    logic [c_MAX_N-1:0]  w_oh_pad;
    logic [c_MAX_PW-1:0] w_ptr_pad;

    always_comb begin
        w_req_pad        = '0;
        w_req_pad[N-1:0] = i_req;
        w_ptr_pad        = '0;
        w_ptr_pad[PW-1:0] = i_ptr;
        w_oh_pad         = rr_first(w_req_pad, w_ptr_pad, N);
        o_onehot         = w_oh_pad[N-1:0];
        o_idx            = '0;
        for (int i = 0; i < N; i++) begin
            if (w_oh_pad[i]) o_idx = PW'(i);
        end
    end

    // Lanes above N are structurally zero.
    if (N < c_MAX_N) begin : g_pad
        logic w_unused_hi;
        assign w_unused_hi = ^w_oh_pad[c_MAX_N-1:N];
    end

endmodule
`default_nettype wire

// File: rtl/axi4_stream_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module : axi4_stream_rr_arb
//  Brief  : Packet-aware round-robin merge of N AXI4-Stream sources into one
//           registered output stream; grant is held until the releasing beat.
//  Rev    : 1.0  initial release
// ============================================================================
module axi4_stream_rr_arb
    import axi4_stream_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int DW  = 16,
    parameter int PKT = 1
) (
    input  wire logic             ACLK,
    input  wire logic             ARESETn,
    input  wire logic [N-1:0]     ena,
    axi4_stream_rr_arb_if.slave   sti,
    axi4_stream_rr_arb_if.master  sto,
    output logic      [N-1:0]     grant,
    output logic                  busy
);

    localparam int KW = DW / 8;
    localparam int PW = $clog2(N);

    arb_state_t     r_state;
    logic [N-1:0]   r_grant;
    logic [PW-1:0]  r_idx;
    logic [PW-1:0]  r_ptr;
    logic           r_busy;
    logic           r_out_valid;
    logic           r_out_last;
    logic [DW-1:0]  r_out_data;
    logic [KW-1:0]  r_out_keep;

    logic [N-1:0]   w_req;
    logic [N-1:0]   w_pick_oh;
    logic [PW-1:0]  w_pick_idx;
    logic           w_own_ready;
    logic           w_own_valid;
    logic           w_own_last;
    logic [DW-1:0]  w_own_data;
    logic [KW-1:0]  w_own_keep;
    logic           w_xfer;
    logic           w_release;

    assign w_req = ena & sti.TVALID;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx)
    );

    // Owner lane select; grant is zero in IDLE so every owner field reads zero there.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        w_own_keep  = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_own_valid = sti.TVALID[i];
                w_own_last  = sti.TLAST[i];
                w_own_data  = sti.TDATA[i*DW +: DW];
                w_own_keep  = sti.TKEEP[i*KW +: KW];
            end
        end
    end

    assign w_own_ready = sto.TREADY | ~r_out_valid;
    assign sti.TREADY  = r_grant & {N{w_own_ready}};
    assign w_xfer      = w_own_valid & w_own_ready;
    assign w_release   = w_xfer & (w_own_last | (PKT == 0));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_idx       <= '0;
            r_ptr       <= PW'(N - 1);
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sto.TREADY) r_out_valid <= 1'b0;
                    if (|w_req) begin
                        r_state <= LOCK;
                        r_grant <= w_pick_oh;
                        r_idx   <= w_pick_idx;
                        r_busy  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (w_own_ready) r_out_valid <= w_own_valid;
                    if (w_release) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= r_idx;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Payload only moves on an accepted beat, so it stays stable under backpressure.
    always_ff @(posedge ACLK) begin
        if (w_xfer) begin
            r_out_data <= w_own_data;
            r_out_keep <= w_own_keep;
            r_out_last <= w_own_last;
        end
    end

    assign sto.TVALID = r_out_valid;
    assign sto.TDATA  = r_out_data;
    assign sto.TKEEP  = r_out_keep;
    assign sto.TLAST  = r_out_last;
    assign grant      = r_grant;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module : tb_axi4_stream_rr_arb
//  Brief  : Directed self-checking bench; PKT=1 and PKT=0 instances share sources.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_axi4_stream_rr_arb;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int KW = DW / 8;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [N-1:0]    ena0, ena1;
    logic [N-1:0]    grant0, grant1;
    logic            busy0, busy1;
    logic            rdy;
    logic [N-1:0]    s_valid, s_last;
    logic [N*DW-1:0] s_data;
    logic [N*KW-1:0] s_keep;

    axi4_stream_rr_arb_if #(.NL(N), .DW(DW)) sti0 ();
    axi4_stream_rr_arb_if #(.NL(N), .DW(DW)) sti1 ();
    axi4_stream_rr_arb_if #(.NL(1), .DW(DW)) sto0 ();
    axi4_stream_rr_arb_if #(.NL(1), .DW(DW)) sto1 ();

    assign sti0.TVALID = s_valid;
    assign sti0.TLAST  = s_last;
    assign sti0.TDATA  = s_data;
    assign sti0.TKEEP  = s_keep;
    assign sti1.TVALID = s_valid;
    assign sti1.TLAST  = s_last;
    assign sti1.TDATA  = s_data;
    assign sti1.TKEEP  = s_keep;
    assign sto0.TREADY = rdy;
    assign sto1.TREADY = rdy;

    axi4_stream_rr_arb #(.N(N), .DW(DW), .PKT(1)) u_dut0 (
        .ACLK(ACLK), .ARESETn(ARESETn), .ena(ena0),
        .sti(sti0), .sto(sto0), .grant(grant0), .busy(busy0)
    );

    axi4_stream_rr_arb #(.N(N), .DW(DW), .PKT(0)) u_dut1 (
        .ACLK(ACLK), .ARESETn(ARESETn), .ena(ena1),
        .sti(sti1), .sto(sto1), .grant(grant1), .busy(busy1)
    );

    always #5 ACLK = ~ACLK;

    int          left [N];
    int          plen [N];
    int          beat [N];
    int          pkt  [N];
    int          sel;
    int          n_checks;
    int          n_errors;
    logic [16:0] obs_q[$];
    logic [16:0] exp_q[$];
    logic        prev_stall;
    logic [16:0] prev_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_src();
        for (int i = 0; i < N; i++) begin
            s_valid[i]          = (left[i] > 0);
            s_last[i]           = (beat[i] == plen[i] - 1);
            s_data[i*DW +: DW]  = {i[3:0], pkt[i][7:0], beat[i][3:0]};
        end
        s_keep = '1;
    endtask

    task automatic clr_src();
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            plen[i] = 1;
            beat[i] = 0;
            pkt[i]  = 0;
        end
        apply_src();
    endtask

    // One clock: sample handshakes at the falling edge, advance sources after the rising edge.
    task automatic cycle();
        logic [N-1:0] x;
        logic [16:0]  w;
        logic         v;
        @(negedge ACLK);
        x = s_valid & ((sel != 0) ? sti1.TREADY : sti0.TREADY);
        v = (sel != 0) ? sto1.TVALID[0] : sto0.TVALID[0];
        w = (sel != 0) ? {sto1.TLAST[0], sto1.TDATA} : {sto0.TLAST[0], sto0.TDATA};
        if (ARESETn) begin
            if (prev_stall) begin
                check("hold_valid", 32'(v), 32'd1);
                check("hold_word", 32'(w), 32'(prev_word));
            end
            if (v && rdy) obs_q.push_back(w);
            prev_stall = v && !rdy;
            prev_word  = w;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge ACLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                beat[i]++;
                if (beat[i] == plen[i]) begin
                    beat[i] = 0;
                    pkt[i]++;
                end
                left[i]--;
            end
        end
        apply_src();
    endtask

    task automatic run(input int n_exp, input int budget);
        for (int k = 0; k < budget && obs_q.size() < n_exp; k++) cycle();
        repeat (4) cycle();
    endtask

    task automatic check_seq(input string tag);
        check($sformatf("%s_len", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("%s_%0d", tag, k),
                  (k < obs_q.size()) ? 32'(obs_q[k]) : 32'hxxxx_xxxx, 32'(exp_q[k]));
        end
        obs_q.delete();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        sel        = 0;
        rdy        = 1'b0;
        ena0       = '0;
        ena1       = '0;
        prev_stall = 1'b0;
        prev_word  = '0;
        ARESETn    = 1'b0;
        clr_src();
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_grant", 32'(grant0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_tvalid", 32'(sto0.TVALID), 32'd0);
        check("rst_tready", 32'(sti0.TREADY), 32'd0);
        ARESETn = 1'b1;

        // All four sources, two 1-beat packets each: strict 0,1,2,3 rotation.
        rdy  = 1'b1;
        ena0 = 4'b1111;
        for (int i = 0; i < N; i++) left[i] = 2;
        apply_src();
        cycle();
        check("t1_grant", 32'(grant0), 32'b0001);
        check("t1_busy", 32'(busy0), 32'd1);
        check("t1_tready", 32'(sti0.TREADY), 32'b0001);
        cycle();
        check("t1_tvalid", 32'(sto0.TVALID), 32'd1);
        check("t1_tdata", 32'(sto0.TDATA), 32'h0000);
        check("t1_tkeep", 32'(sto0.TKEEP), 32'b11);
        check("t1_tlast", 32'(sto0.TLAST), 32'd1);
        check("t1_release", 32'(grant0), 32'd0);
        run(8, 40);
        exp_q = '{17'h1_0000, 17'h1_1000, 17'h1_2000, 17'h1_3000,
                  17'h1_0010, 17'h1_1010, 17'h1_2010, 17'h1_3010};
        check_seq("t1");

        // Source 2 four-beat packet; source 0 joins at beat 2 and must wait.
        clr_src();
        left[2] = 4;
        plen[2] = 4;
        apply_src();
        cycle();
        check("t2_grant", 32'(grant0), 32'b0100);
        cycle();
        cycle();
        left[0] = 1;
        apply_src();
        run(5, 40);
        exp_q = '{17'h0_2000, 17'h0_2001, 17'h0_2002, 17'h1_2003, 17'h1_0000};
        check_seq("t2");

        // Backpressure for three cycles in the middle of a source 1 packet.
        clr_src();
        left[1] = 3;
        plen[1] = 3;
        apply_src();
        repeat (3) cycle();
        rdy = 1'b0;
        #1;
        check("t3_tready_stall", 32'(sti0.TREADY), 32'd0);
        check("t3_grant", 32'(grant0), 32'b0010);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("t3_data_%0d", k), 32'(sto0.TDATA), 32'h1001);
            check($sformatf("t3_valid_%0d", k), 32'(sto0.TVALID), 32'd1);
            check($sformatf("t3_last_%0d", k), 32'(sto0.TLAST), 32'd0);
            check($sformatf("t3_tready_%0d", k), 32'(sti0.TREADY), 32'd0);
        end
        rdy = 1'b1;
        run(3, 40);
        exp_q = '{17'h0_1000, 17'h0_1001, 17'h1_1002};
        check_seq("t3");

        // Enable mask 0101: only sources 2 and 0 alternate.
        clr_src();
        ena0 = 4'b0101;
        for (int i = 0; i < N; i++) left[i] = 2;
        apply_src();
        run(4, 40);
        check("t4_masked_idle", 32'(grant0), 32'd0);
        exp_q = '{17'h1_2000, 17'h1_0000, 17'h1_2010, 17'h1_0010};
        check_seq("t4a");

        // Dropping ena[2] mid-packet must not cut the packet short.
        clr_src();
        left[2] = 3;
        plen[2] = 3;
        left[0] = 1;
        apply_src();
        cycle();
        check("t4b_grant", 32'(grant0), 32'b0100);
        cycle();
        ena0 = 4'b0001;
        run(4, 40);
        exp_q = '{17'h0_2000, 17'h0_2001, 17'h1_2002, 17'h1_0000};
        check_seq("t4b");

        // Per-beat release: sources 1 and 3 interleave beat by beat.
        clr_src();
        ena0       = '0;
        sel        = 1;
        prev_stall = 1'b0;
        ena1       = 4'b1010;
        left[1] = 3; plen[1] = 3;
        left[3] = 3; plen[3] = 3;
        apply_src();
        run(6, 60);
        exp_q = '{17'h0_1000, 17'h0_3000, 17'h0_1001, 17'h0_3001, 17'h1_1002, 17'h1_3002};
        check_seq("t5");

        // Asynchronous reset in the middle of a packet.
        sel        = 0;
        ena1       = '0;
        ena0       = 4'b1111;
        prev_stall = 1'b0;
        clr_src();
        left[1] = 4;
        plen[1] = 4;
        apply_src();
        repeat (3) cycle();
        #2;
        ARESETn = 1'b0;
        #1;
        check("t6_rst_tvalid", 32'(sto0.TVALID), 32'd0);
        check("t6_rst_grant", 32'(grant0), 32'd0);
        check("t6_rst_busy", 32'(busy0), 32'd0);
        check("t6_rst_tready", 32'(sti0.TREADY), 32'd0);
        clr_src();
        for (int i = 0; i < N; i++) left[i] = 1;
        apply_src();
        @(posedge ACLK);
        #1;
        ARESETn    = 1'b1;
        prev_stall = 1'b0;
        obs_q.delete();
        cycle();
        check("t6_first_grant", 32'(grant0), 32'b0001);
        run(4, 40);
        exp_q = '{17'h1_0000, 17'h1_1000, 17'h1_2000, 17'h1_3000};
        check_seq("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
